dcm_drp_ctrl: RTL and testbench
===============================

DCM_DRP_CTRL -- requirements
Module: dcm_drp_ctrl

Interface
REQ-001 Parameter TO_CYC, default 64: maximum cycles to wait for drp_drdy after a strobe (range 2..255).
REQ-002 Parameter RST_CYC, default 8: cycles dcm_rst is held high in a reset sequence (range 1..255).
REQ-003 CLK  in  1  the single clock; all logic is on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on CLK.
REQ-005 req_valid  in  1  host requests a DRP access.
REQ-006 req_ready  out  1  controller accepts a request this cycle.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  7  DRP address.
REQ-009 req_wdata  in  16  write data.
REQ-010 rsp_valid  out  1  one-cycle pulse marking access completion.
REQ-011 rsp_data  out  16  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-013 rst_req  in  1  level request to re-run the DCM reset sequence.
REQ-014 drp_daddr / drp_di  out  7 / 16  DRP address and write data to the DCM.
REQ-015 drp_den / drp_dwe  out  1 / 1  DRP enable strobe and write enable.
REQ-016 drp_do / drp_drdy  in  16 / 1  DRP read data and ready from the DCM.
REQ-017 dcm_rst  out  1  active-high DCM reset.
REQ-018 dcm_locked  in  1  DCM lock status.
REQ-019 locked  out  1  registered lock status, gated by state.

Function
REQ-020 The FSM SHALL have the states RST_DCM, WAIT_LOCK, IDLE, STROBE, WAIT_RDY and RESP.
REQ-021 RST_DCM: dcm_rst=1 for exactly RST_CYC cycles, then go to WAIT_LOCK.
REQ-022 WAIT_LOCK: dcm_rst=0; go to IDLE on the first cycle dcm_locked is sampled 1; no timeout.
REQ-023 IDLE: req_ready=1, and only here; a request is accepted when req_valid and req_ready are both high on a clock edge.
REQ-024 On acceptance, capture req_addr, req_wdata and req_write, then go to STROBE.
REQ-025 STROBE lasts exactly one cycle: drp_den=1 and drp_dwe=captured req_write.
REQ-026 drp_daddr and drp_di SHALL hold the captured values from STROBE until RESP ends, and 0 otherwise.
REQ-027 drp_den and drp_dwe SHALL be 0 in every state except STROBE.
REQ-028 drp_drdy SHALL be ignored during STROBE; it is sampled in WAIT_RDY only.
REQ-029 WAIT_RDY: an 8-bit counter starts at 0 and increments each cycle. On drp_drdy=1, go to RESP with rsp_data=drp_do for a read or 0 for a write, and rsp_err=0.
REQ-030 WAIT_RDY timeout: if the counter reaches TO_CYC-1 without drp_drdy, go to RESP with rsp_data=0 and rsp_err=1.
REQ-031 If drp_drdy arrives in the same cycle as the timeout, it SHALL win (rsp_err=0).
REQ-032 RESP lasts one cycle: rsp_valid=1, then go to IDLE, or to RST_DCM if a reset is pending.
REQ-033 Minimum latency SHALL be 3 cycles from the acceptance edge to rsp_valid, with drp_drdy on the first WAIT_RDY cycle.
REQ-034 rsp_data and rsp_err SHALL hold their values until the next RESP.
REQ-035 Reset request handling:
- In IDLE, rst_req=1 goes to RST_DCM, taking priority over a simultaneous req_valid (not accepted).
- In STROBE or WAIT_RDY, rst_req sets a pending flag; the access completes first.
- The pending flag clears on entry to RST_DCM.
REQ-036 rst_req seen in RST_DCM or WAIT_LOCK SHALL be ignored; a level still high in IDLE restarts the sequence.
REQ-037 locked SHALL be a one-cycle-registered copy of dcm_locked in IDLE, STROBE, WAIT_RDY and RESP, and 0 in RST_DCM and WAIT_LOCK.
REQ-038 Loss of dcm_locked SHALL NOT abort an access or change state.
REQ-039 drp_drdy in any state other than WAIT_RDY SHALL be ignored.

Reset
REQ-040 While RST_N=0, all outputs SHALL be 0 except dcm_rst=1; the state is RST_DCM and the counters are 0.
REQ-041 After RST_N deasserts, the RST_DCM sequence SHALL run in full (RST_CYC cycles).
REQ-042 RST_N assertion mid-access SHALL abort the access with no rsp_valid.

Verification
REQ-043 Reset, dcm_locked=1 at cycle 3 -> dcm_rst high for exactly 8 cycles, locked=1 one cycle after IDLE entry, req_ready=1.
REQ-044 Read of addr 7'h11, DCM returns 16'hA5C3 with drdy 2 cycles after den -> single den pulse, dwe=0, rsp_valid pulse, rsp_data=16'hA5C3, rsp_err=0.
REQ-045 Write of 16'h1234 to 7'h50, drdy on the first WAIT_RDY cycle -> den=dwe=1 for one cycle, di=16'h1234, rsp_valid exactly 3 cycles after acceptance, rsp_data=0.
REQ-046 Read with drdy never asserted, TO_CYC=64 -> rsp_valid with rsp_err=1 and rsp_data=0 exactly 64 cycles after STROBE; the next request is accepted normally.
REQ-047 rst_req pulsed during WAIT_RDY -> the access completes with rsp_valid, then dcm_rst rises the next cycle; req_valid held high is not accepted until lock returns.
REQ-048 Spurious drdy in IDLE, and RST_N pulsed low during WAIT_RDY -> no rsp_valid, outputs at reset values, full reset sequence rerun.

Source files
------------

// File: rtl/dcm_drp_ctrl.sv
// DRP access controller for a DCM: runs the DCM reset/lock sequence, then
// serialises host read/write requests onto the DRP port with a ready timeout.
module dcm_drp_ctrl #(
  parameter int TO_CYC  = 64,
  parameter int RST_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // Host side. A request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  input  logic        rst_req,
  // DRP side
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  // DCM control/status
  output logic        dcm_rst,
  input  logic        dcm_locked,
  output logic        locked,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_RST_DCM   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_STROBE    = 3'd3;
  localparam logic [2:0] S_WAIT_RDY  = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [7:0] RST_LAST = 8'(RST_CYC - 1);
  localparam logic [7:0] TO_LAST  = 8'(TO_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_inc;
  logic        timeout;
  logic        pend_q;
  logic        wr_q;
  logic        lock_q;
  logic [6:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;
  logic        in_access;

  assign cnt_inc = cnt_q + 8'd1;
  // The counter reaches TO_CYC-1 on the edge that leaves WAIT_RDY, so the
  // response lands TO_CYC cycles after the strobe.
  assign timeout = (cnt_inc == TO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST_DCM:   if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (dcm_locked) state_d = S_IDLE;
      S_IDLE: begin
        if (rst_req)        state_d = S_RST_DCM;
        else if (req_valid) state_d = S_STROBE;
      end
      S_STROBE:    state_d = S_WAIT_RDY;
      S_WAIT_RDY:  if (drp_drdy || timeout) state_d = S_RESP;
      S_RESP:      state_d = pend_q ? S_RST_DCM : S_IDLE;
      default:     state_d = S_RST_DCM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST_DCM;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      wr_q       <= 1'b0;
      lock_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= dcm_locked;

      if (state_d == state_q && (state_q == S_RST_DCM || state_q == S_WAIT_RDY))
        cnt_q <= cnt_inc;
      else
        cnt_q <= '0;

      // A reset request during an access is deferred until its response.
      if (state_d == S_RST_DCM)
        pend_q <= 1'b0;
      else if ((state_q == S_STROBE || state_q == S_WAIT_RDY) && rst_req)
        pend_q <= 1'b1;

      if (state_q == S_IDLE && state_d == S_STROBE) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_write;
      end

      // drdy wins over a coincident timeout.
      if (state_q == S_WAIT_RDY && state_d == S_RESP) begin
        rsp_err_q  <= ~drp_drdy;
        rsp_data_q <= (drp_drdy && !wr_q) ? drp_do : 16'd0;
      end
    end
  end

  assign in_access = (state_q == S_STROBE) || (state_q == S_WAIT_RDY) || (state_q == S_RESP);

  assign dcm_rst   = (state_q == S_RST_DCM);
  assign req_ready = (state_q == S_IDLE);
  assign drp_den   = (state_q == S_STROBE);
  assign drp_dwe   = (state_q == S_STROBE) && wr_q;
  assign drp_daddr = in_access ? addr_q : 7'd0;
  assign drp_di    = in_access ? wdata_q : 16'd0;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign locked    = lock_q && (in_access || state_q == S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcm_drp_ctrl.sv
// Directed bench for dcm_drp_ctrl: reset/lock sequence, reads, writes,
// timeout edges, deferred and immediate reset requests, and async abort.
module tb_dcm_drp_ctrl;

  localparam logic [2:0] S_RST_DCM   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [6:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rst_req;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        dcm_rst, dcm_locked, locked;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcm_drp_ctrl #(.TO_CYC(64), .RST_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rst_req(rst_req),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .dcm_rst(dcm_rst), .dcm_locked(dcm_locked), .locked(locked),
    .dbg_state(dbg_state)
  );

  task automatic test_reset();
    int n;
    rst_n = 1'b0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    rst_req = 0; drp_do = '0; drp_drdy = 0; dcm_locked = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dcm_rst, req_ready, rsp_valid, rsp_err, locked, drp_den, drp_dwe} !== 7'b1000000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 1000000",
        {dcm_rst, req_ready, rsp_valid, rsp_err, locked, drp_den, drp_dwe});
    end
    checks++;
    if ({rsp_data, drp_daddr, drp_di} !== 39'd0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", {rsp_data, drp_daddr, drp_di});
    end
    checks++;
    if (dbg_state !== S_RST_DCM) begin
      failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_RST_DCM);
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) dcm_locked = 1'b1;
      if (!dcm_rst) break;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 8) begin
      failures++; $display("FAIL rst_len: got %0d cycles expected 8", n);
    end
    checks++;
    if ({dbg_state, locked, req_ready} !== {S_WAIT_LOCK, 2'b00}) begin
      failures++; $display("FAIL wait_lock: got state=%0d locked=%b ready=%b expected 1 0 0",
        dbg_state, locked, req_ready);
    end
    @(negedge clk);
    checks++;
    if ({dbg_state, locked, req_ready} !== {S_IDLE, 2'b11}) begin
      failures++; $display("FAIL idle_entry: got state=%0d locked=%b ready=%b expected 2 1 1",
        dbg_state, locked, req_ready);
    end
  endtask

  task automatic test_read();
    req_valid = 1; req_write = 0; req_addr = 7'h11; req_wdata = 16'h0000;
    @(negedge clk);
    req_valid = 0;
    checks++;
    if ({drp_den, drp_dwe, drp_daddr, rsp_valid} !== {1'b1, 1'b0, 7'h11, 1'b0}) begin
      failures++; $display("FAIL read_strobe: got den=%b dwe=%b addr=%h rv=%b expected 1 0 11 0",
        drp_den, drp_dwe, drp_daddr, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({drp_den, drp_daddr, rsp_valid} !== {1'b0, 7'h11, 1'b0}) begin
      failures++; $display("FAIL read_wait: got den=%b addr=%h rv=%b expected 0 11 0",
        drp_den, drp_daddr, rsp_valid);
    end
    @(negedge clk);
    drp_drdy = 1; drp_do = 16'hA5C3;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, drp_den} !== {1'b1, 1'b0, 16'hA5C3, 1'b0}) begin
      failures++; $display("FAIL read_resp: got rv=%b err=%b data=%h den=%b expected 1 0 a5c3 0",
        rsp_valid, rsp_err, rsp_data, drp_den);
    end
    drp_drdy = 0; drp_do = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, drp_daddr, req_ready} !== {1'b0, 16'hA5C3, 7'h00, 1'b1}) begin
      failures++; $display("FAIL read_after: got rv=%b data=%h addr=%h ready=%b expected 0 a5c3 00 1",
        rsp_valid, rsp_data, drp_daddr, req_ready);
    end
  endtask

  task automatic test_write();
    req_valid = 1; req_write = 1; req_addr = 7'h50; req_wdata = 16'h1234;
    @(negedge clk);
    req_valid = 0;
    checks++;
    if ({rsp_valid, drp_den, drp_dwe, drp_daddr, drp_di} !== {3'b011, 7'h50, 16'h1234}) begin
      failures++; $display("FAIL write_strobe: got rv=%b den=%b dwe=%b addr=%h di=%h expected 0 1 1 50 1234",
        rsp_valid, drp_den, drp_dwe, drp_daddr, drp_di);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, drp_den, drp_dwe, drp_di} !== {3'b000, 16'h1234}) begin
      failures++; $display("FAIL write_wait: got rv=%b den=%b dwe=%b di=%h expected 0 0 0 1234",
        rsp_valid, drp_den, drp_dwe, drp_di);
    end
    drp_drdy = 1; drp_do = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 16'h0000}) begin
      failures++; $display("FAIL write_resp: got rv=%b err=%b data=%h expected 1 0 0000",
        rsp_valid, rsp_err, rsp_data);
    end
    drp_drdy = 0; drp_do = '0;
    @(negedge clk);
    checks++;
    if ({dbg_state, rsp_valid, drp_di} !== {S_IDLE, 1'b0, 16'h0000}) begin
      failures++; $display("FAIL write_after: got state=%0d rv=%b di=%h expected 2 0 0000",
        dbg_state, rsp_valid, drp_di);
    end
  endtask

  task automatic test_timeout();
    int n;
    req_valid = 1; req_write = 0; req_addr = 7'h22;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    checks++;
    if (n !== 64) begin
      failures++; $display("FAIL timeout_latency: got %0d cycles after strobe expected 64", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 16'h0000}) begin
      failures++; $display("FAIL timeout_resp: got rv=%b err=%b data=%h expected 1 1 0000",
        rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 7'h33;
    @(negedge clk);
    req_valid = 0;
    checks++;
    if ({drp_den, drp_daddr} !== {1'b1, 7'h33}) begin
      failures++; $display("FAIL after_timeout_strobe: got den=%b addr=%h expected 1 33", drp_den, drp_daddr);
    end
    @(negedge clk);
    drp_drdy = 1; drp_do = 16'h0BEE;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 16'h0BEE}) begin
      failures++; $display("FAIL after_timeout_resp: got rv=%b err=%b data=%h expected 1 0 0bee",
        rsp_valid, rsp_err, rsp_data);
    end
    drp_drdy = 0; drp_do = '0;
    @(negedge clk);
  endtask

  task automatic test_drdy_at_timeout();
    req_valid = 1; req_write = 0; req_addr = 7'h44;
    @(negedge clk);
    req_valid = 0;
    repeat (63) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL edge_wait: got rv=%b expected 0", rsp_valid);
    end
    drp_drdy = 1; drp_do = 16'hC0DE;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 16'hC0DE}) begin
      failures++; $display("FAIL edge_resp: got rv=%b err=%b data=%h expected 1 0 c0de",
        rsp_valid, rsp_err, rsp_data);
    end
    drp_drdy = 0; drp_do = '0;
    @(negedge clk);
  endtask

  task automatic test_rst_req_pending();
    int n;
    logic den_seen;
    req_valid = 1; req_write = 0; req_addr = 7'h0A;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_req = 1;
    @(negedge clk);
    rst_req = 0; drp_drdy = 1; drp_do = 16'h5555;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, dcm_rst} !== {1'b1, 16'h5555, 1'b0}) begin
      failures++; $display("FAIL pend_resp: got rv=%b data=%h dcm_rst=%b expected 1 5555 0",
        rsp_valid, rsp_data, dcm_rst);
    end
    drp_drdy = 0; drp_do = '0;
    req_valid = 1; req_write = 1; req_addr = 7'h05; req_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({dcm_rst, req_ready, locked, drp_den} !== 4'b1000) begin
      failures++; $display("FAIL pend_rst: got dcm_rst=%b ready=%b locked=%b den=%b expected 1 0 0 0",
        dcm_rst, req_ready, locked, drp_den);
    end
    dcm_locked = 0;
    n = 1;
    den_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (drp_den) den_seen = 1;
      if (!dcm_rst) break;
      n++;
    end
    checks++;
    if (n !== 8) begin
      failures++; $display("FAIL pend_rst_len: got %0d cycles expected 8", n);
    end
    repeat (4) begin
      @(negedge clk);
      if (drp_den) den_seen = 1;
    end
    checks++;
    if ({den_seen, req_ready, dbg_state} !== {2'b00, S_WAIT_LOCK}) begin
      failures++; $display("FAIL lock_wait: got den_seen=%b ready=%b state=%0d expected 0 0 1",
        den_seen, req_ready, dbg_state);
    end
    dcm_locked = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL relock: got ready=%b expected 1", req_ready);
    end
    @(negedge clk);
    req_valid = 0;
    checks++;
    if ({drp_den, drp_dwe, drp_daddr, drp_di} !== {2'b11, 7'h05, 16'hBEEF}) begin
      failures++; $display("FAIL held_req_strobe: got den=%b dwe=%b addr=%h di=%h expected 1 1 05 beef",
        drp_den, drp_dwe, drp_daddr, drp_di);
    end
    @(negedge clk);
    drp_drdy = 1;
    @(negedge clk);
    drp_drdy = 0;
    @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE) begin
      failures++; $display("FAIL pend_cleared: got state=%0d expected 2", dbg_state);
    end
  endtask

  task automatic test_idle_rst_priority();
    logic ready_seen;
    rst_req = 1; req_valid = 1; req_write = 0; req_addr = 7'h7F;
    @(negedge clk);
    rst_req = 0; req_valid = 0;
    checks++;
    if ({dcm_rst, drp_den, dbg_state} !== {2'b10, S_RST_DCM}) begin
      failures++; $display("FAIL idle_rst_priority: got dcm_rst=%b den=%b state=%0d expected 1 0 0",
        dcm_rst, drp_den, dbg_state);
    end
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ready_seen = 1;
        break;
      end
    end
    checks++;
    if (ready_seen !== 1'b1) begin
      failures++; $display("FAIL idle_rst_relock: got ready_seen=%b expected 1", ready_seen);
    end
  endtask

  task automatic test_abort();
    int n;
    logic rv_seen;
    req_valid = 1; req_write = 0; req_addr = 7'h12;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    drp_drdy = 1; drp_do = 16'h1357;
    @(negedge clk);
    drp_drdy = 0;
    @(negedge clk);
    // spurious drdy while idle
    drp_drdy = 1; drp_do = 16'hFFFF;
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rv_seen = 1;
    end
    checks++;
    if ({rv_seen, dbg_state, rsp_data} !== {1'b0, S_IDLE, 16'h1357}) begin
      failures++; $display("FAIL spurious_drdy: got rv_seen=%b state=%0d data=%h expected 0 2 1357",
        rv_seen, dbg_state, rsp_data);
    end
    drp_drdy = 0;
    req_valid = 1; req_write = 1; req_addr = 7'h2A; req_wdata = 16'h7777;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_n = 0; drp_drdy = 1;
    #1;
    checks++;
    if ({dcm_rst, rsp_valid, drp_den, drp_dwe, req_ready, locked, rsp_err} !== 7'b1000000) begin
      failures++; $display("FAIL abort_ctrl: got %b expected 1000000",
        {dcm_rst, rsp_valid, drp_den, drp_dwe, req_ready, locked, rsp_err});
    end
    checks++;
    if ({rsp_data, drp_daddr, drp_di, dbg_state} !== {39'd0, S_RST_DCM}) begin
      failures++; $display("FAIL abort_data: got data=%h addr=%h di=%h state=%0d expected 0 0 0 0",
        rsp_data, drp_daddr, drp_di, dbg_state);
    end
    @(negedge clk);
    rst_n = 1; drp_drdy = 0;
    n = 0;
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) rv_seen = 1;
      if (!dcm_rst) break;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 8) begin
      failures++; $display("FAIL abort_rst_len: got %0d cycles expected 8", n);
    end
    @(negedge clk);
    checks++;
    if ({rv_seen, req_ready} !== 2'b01) begin
      failures++; $display("FAIL abort_no_rsp: got rv_seen=%b ready=%b expected 0 1", rv_seen, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_drdy_at_timeout();
    test_rst_req_pending();
    test_idle_rst_priority();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
